fir_feeder: RTL and testbench

- Upstream-facing driver for the folded 8-tap FIR datapath/control pair.
- Buffers incoming samples in a small FIFO and issues them one at a time to the filter's en/x/ready interface.
- Captures each filter result on valid into an output register with a valid/ready handshake toward downstream.
- Sits between the sample source and the filter top; it is the initiator side of the filter's en/ready/valid protocol.

---
 rtl/fir_pkg.sv | 14 +
 rtl/feeder_fifo.sv | 61 ++++++
 rtl/fir_feeder.sv | 144 ++++++++++++++
 tb/tb_fir_feeder.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR feeder: data width, result counter width
// and the feeder state encoding.
package fir_pkg;

  localparam int FIR_DATA_W = 8;
  localparam int RES_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/feeder_fifo.sv
// Small synchronous FIFO buffering upstream samples ahead of the filter.
// Full/empty come from a registered occupancy count, so a pop in a given
// cycle never opens space for a push in that same cycle.
module feeder_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q;
  logic [PTR_W-1:0]  rdPtr_q;
  logic [PTR_W:0]    count_q;
  logic              doPush;
  logic              doPop;

  assign full_o  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rdPtr_q];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  // Storage array written at the tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fir_feeder.sv
// Initiator side of the folded FIR en/ready/valid protocol. Samples are
// queued in feeder_fifo, issued one at a time, and each filter result is
// held for downstream behind a valid/ready handshake. A WAIT that sees no
// result within TIMEOUT cycles drops the sample and sets a sticky error.
// Optional build macro FEEDER_RESCNT_EN adds a 16-bit delivered-result
// counter on res_count; without it res_count is tied to zero.
module fir_feeder
  import fir_pkg::*;
#(
  parameter int DATA_W     = FIR_DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [DATA_W-1:0]    s_data,
  output logic                 s_ready,
  output logic                 fir_en,
  output logic [DATA_W-1:0]    fir_x,
  input  logic                 fir_ready,
  input  logic                 fir_valid,
  input  logic [DATA_W-1:0]    fir_y,
  output logic                 m_valid,
  output logic [DATA_W-1:0]    m_data,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 err_timeout,
  output logic [RES_CNT_W-1:0] res_count
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  feeder_state_t     state_q;
  logic              fir_en_q;
  logic [DATA_W-1:0] fir_x_q;
  logic              m_valid_q;
  logic [DATA_W-1:0] m_data_q;
  logic              err_q;
  logic [TCNT_W-1:0] waitCnt_q;
  logic [TCNT_W-1:0] waitCnt_d;

  logic              fifoFull;
  logic              fifoEmpty;
  logic [DATA_W-1:0] fifoHead;
  logic              push;
  logic              pop;
  logic              issueOk;

  // Ready is held low while reset is asserted so every output reads zero
  // during reset, then reflects free space from the first cycle after.
  assign s_ready   = !fifoFull && !rst;
  assign push      = s_valid && s_ready;
  assign pop       = (state_q == ISSUE);
  assign issueOk   = !fifoEmpty && fir_ready && (!m_valid_q || m_ready);
  assign waitCnt_d = waitCnt_q + TCNT_W'(1);

  assign fir_en      = fir_en_q;
  assign fir_x       = fir_x_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != IDLE) || !fifoEmpty;

  feeder_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (s_data),
    .pop_i   (pop),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .head_o  (fifoHead)
  );

  // Issue/wait sequencer with its registered strobe, result holding
  // register and timeout watchdog. waitCnt_d counts WAIT cycles completed,
  // so the abort lands exactly TIMEOUT cycles after entering WAIT; a result
  // arriving in that same cycle still wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      fir_en_q  <= 1'b0;
      fir_x_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      err_q     <= 1'b0;
      waitCnt_q <= '0;
    end else begin
      fir_en_q <= 1'b0;
      if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (issueOk) begin
            state_q  <= ISSUE;
            fir_en_q <= 1'b1;
            fir_x_q  <= fifoHead;
          end
        end
        ISSUE: begin
          waitCnt_q <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          waitCnt_q <= waitCnt_d;
          if (fir_valid) begin
            m_data_q  <= fir_y;
            m_valid_q <= 1'b1;
            state_q   <= IDLE;
          end else if (waitCnt_d == TCNT_W'(TIMEOUT)) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef FEEDER_RESCNT_EN
  logic [RES_CNT_W-1:0] resCount_q;

  // Count every result handed downstream, wrapping at the counter width.
  always_ff @(posedge clk) begin
    if (rst) begin
      resCount_q <= '0;
    end else if (m_valid_q && m_ready) begin
      resCount_q <= resCount_q + RES_CNT_W'(1);
    end
  end

  assign res_count = resCount_q;
`else
  assign res_count = '0;
`endif

endmodule

// File: tb/tb_fir_feeder.sv
// Self-checking bench for fir_feeder with a behavioural filter model
// (y = x + 1, fixed latency) and result/sample scoreboards.
module tb_fir_feeder;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 31;
  localparam int LAT        = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_ready;
  logic              fir_en;
  logic [DATA_W-1:0] fir_x;
  logic              fir_ready;
  logic              fir_valid;
  logic [DATA_W-1:0] fir_y;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready = 1'b1;
  logic              busy;
  logic              err_timeout;
  logic [15:0]       res_count;

  logic              allowReady = 1'b1;
  logic              modelReady = 1'b1;
  logic              modelValid = 1'b0;
  logic              strayValid = 1'b0;
  logic [DATA_W-1:0] yDrive = '0;

  int errorCount = 0;
  int checkCount = 0;
  int enCount    = 0;
  int dropNext   = 0;

  logic [DATA_W-1:0] expX[$];
  logic [DATA_W-1:0] expY[$];

  logic [DATA_W-1:0] modelHeld = '0;
  logic [DATA_W-1:0] modelExp;
  logic [DATA_W-1:0] monExp;
  logic              modelBusy = 1'b0;
  logic              modelDrop = 1'b0;
  logic              prevEn = 1'b0;
  int                modelCd = 0;

`ifdef FEEDER_RESCNT_EN
  localparam logic [15:0] RES_EXP = 16'd5;
`else
  localparam logic [15:0] RES_EXP = 16'd0;
`endif

  assign fir_ready = allowReady && modelReady;
  assign fir_valid = modelValid || strayValid;
  assign fir_y     = yDrive;

  fir_feeder #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .fir_en      (fir_en),
    .fir_x       (fir_x),
    .fir_ready   (fir_ready),
    .fir_valid   (fir_valid),
    .fir_y       (fir_y),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .busy        (busy),
    .err_timeout (err_timeout),
    .res_count   (res_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Filter model: checks each issued sample against the scoreboard and
  // answers with x+1 after LAT cycles, or stays silent when told to drop.
  always @(negedge clk) begin
    modelValid = 1'b0;
    if (rst) begin
      modelBusy = 1'b0;
      modelCd   = 0;
      prevEn    = 1'b0;
    end else begin
      if (modelBusy) begin
        modelCd = modelCd - 1;
        if (modelCd == 0) begin
          modelBusy = 1'b0;
          if (!modelDrop) begin
            modelValid = 1'b1;
            yDrive     = modelHeld + 8'd1;
          end
        end
      end
      if (fir_en) begin
        checkCount++;
        if (prevEn) begin
          errorCount++;
          $display("[TB] FAIL fir_en_width: fir_en high for 2 cycles, required 1");
        end
        checkCount++;
        if (expX.size() == 0) begin
          errorCount++;
          $display("[TB] FAIL issue_order: unexpected issue x=0x%02h, none required", fir_x);
        end else begin
          modelExp = expX.pop_front();
          if (fir_x !== modelExp) begin
            errorCount++;
            $display("[TB] FAIL issue_order: fir_x=0x%02h, required 0x%02h", fir_x, modelExp);
          end
        end
        enCount++;
        modelHeld = fir_x;
        modelBusy = 1'b1;
        if (dropNext > 0) begin
          dropNext--;
          modelDrop = 1'b1;
          modelCd   = TIMEOUT + 5;
        end else begin
          modelDrop = 1'b0;
          modelCd   = LAT;
        end
      end
      prevEn = fir_en;
    end
    modelReady = !modelBusy;
  end

  // Result monitor: every downstream transfer must match the next expected result.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      checkCount++;
      if (expY.size() == 0) begin
        errorCount++;
        $display("[TB] FAIL result_order: unexpected m_data=0x%02h, none required", m_data);
      end else begin
        monExp = expY.pop_front();
        if (m_data !== monExp) begin
          errorCount++;
          $display("[TB] FAIL result_order: m_data=0x%02h, required 0x%02h", m_data, monExp);
        end
      end
    end
  end

  // Present one sample and wait (bounded) until it is accepted.
  task automatic applyStimulus(input logic [DATA_W-1:0] d, input bit expectResult);
    bit accepted = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int c = 0; c < 500 && !accepted; c++) begin
      @(negedge clk);
      if (s_ready) begin
        accepted = 1'b1;
        expX.push_back(d);
        if (expectResult) expY.push_back(d + 8'd1);
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    checkCount++;
    if (!accepted) begin
      errorCount++;
      $display("[TB] FAIL push_accept: sample 0x%02h not accepted, required accepted", d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if (s_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_s_ready: got %b, required 0", s_ready); end
    checkCount++;
    if (fir_en !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_fir_en: got %b, required 0", fir_en); end
    checkCount++;
    if (m_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_m_valid: got %b, required 0", m_valid); end
    checkCount++;
    if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
    checkCount++;
    if (err_timeout !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_err: got %b, required 0", err_timeout); end
    checkCount++;
    if (res_count !== 16'd0) begin errorCount++; $display("[TB] FAIL reset_res_count: got %0d, required 0", res_count); end
    checkCount++;
    if (m_data !== 8'h00) begin errorCount++; $display("[TB] FAIL reset_m_data: got 0x%02h, required 0x00", m_data); end
    rst = 1'b0;
    #1;
    checkCount++;
    if (s_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL post_reset_s_ready: got %b, required 1", s_ready); end
  endtask

  task automatic test_basic();
    int en0 = enCount;
    m_ready    = 1'b1;
    allowReady = 1'b1;
    applyStimulus(8'h10, 1'b1);
    applyStimulus(8'h20, 1'b1);
    applyStimulus(8'h30, 1'b1);
    for (int c = 0; c < 1000 && expY.size() != 0; c++) @(posedge clk);
    #1;
    checkCount++;
    if (expY.size() != 0) begin errorCount++; $display("[TB] FAIL basic_drain: %0d results pending, required 0", expY.size()); end
    checkCount++;
    if (enCount != en0 + 3) begin errorCount++; $display("[TB] FAIL basic_issues: got %0d issues, required 3", enCount - en0); end
    @(posedge clk);
    #1;
    checkCount++;
    if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL basic_busy: got %b, required 0", busy); end
  endtask

  task automatic test_back_to_back();
    int en0 = enCount;
    allowReady = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) applyStimulus(8'h40 + 8'(i), 1'b1);
    s_valid = 1'b1;
    s_data  = 8'h48;
    @(negedge clk);
    checkCount++;
    if (s_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL full_s_ready: got %b, required 0", s_ready); end
    repeat (4) @(posedge clk);
    #1;
    checkCount++;
    if (s_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL full_hold: s_ready=%b, required 0", s_ready); end
    checkCount++;
    if (enCount != en0) begin errorCount++; $display("[TB] FAIL stall_no_issue: got %0d issues, required 0", enCount - en0); end
    allowReady = 1'b1;
    applyStimulus(8'h48, 1'b1);
    checkCount++;
    if (enCount != en0 + 1) begin errorCount++; $display("[TB] FAIL ninth_held: %0d issues before accept, required 1", enCount - en0); end
    for (int c = 0; c < 2000 && expY.size() != 0; c++) @(posedge clk);
    #1;
    checkCount++;
    if (expY.size() != 0) begin errorCount++; $display("[TB] FAIL b2b_drain: %0d results pending, required 0", expY.size()); end
  endtask

  task automatic test_backpressure();
    int en0 = enCount;
    bit seen = 1'b0;
    m_ready = 1'b0;
    applyStimulus(8'h50, 1'b1);
    applyStimulus(8'h60, 1'b1);
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (m_valid) seen = 1'b1;
    end
    checkCount++;
    if (!seen) begin errorCount++; $display("[TB] FAIL bp_first_valid: m_valid=0, required 1"); end
    repeat (25) @(posedge clk);
    #1;
    checkCount++;
    if (m_valid !== 1'b1) begin errorCount++; $display("[TB] FAIL bp_hold_valid: got %b, required 1", m_valid); end
    checkCount++;
    if (m_data !== 8'h51) begin errorCount++; $display("[TB] FAIL bp_hold_data: got 0x%02h, required 0x51", m_data); end
    checkCount++;
    if (enCount != en0 + 1) begin errorCount++; $display("[TB] FAIL bp_no_issue: got %0d issues, required 1", enCount - en0); end
    m_ready = 1'b1;
    for (int c = 0; c < 1000 && expY.size() != 0; c++) @(posedge clk);
    #1;
    checkCount++;
    if (expY.size() != 0) begin errorCount++; $display("[TB] FAIL bp_drain: %0d results pending, required 0", expY.size()); end
    checkCount++;
    if (enCount != en0 + 2) begin errorCount++; $display("[TB] FAIL bp_issues: got %0d issues, required 2", enCount - en0); end
  endtask

  task automatic test_timeout();
    bit found = 1'b0;
    m_ready  = 1'b1;
    dropNext = 1;
    applyStimulus(8'h70, 1'b0);
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk);
      #1;
      if (fir_en) found = 1'b1;
    end
    checkCount++;
    if (!found) begin errorCount++; $display("[TB] FAIL to_issue: fir_en=0, required 1"); end
    @(posedge clk);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    checkCount++;
    if (err_timeout !== 1'b0) begin errorCount++; $display("[TB] FAIL to_early: err_timeout=%b at %0d cycles, required 0", err_timeout, TIMEOUT - 1); end
    @(posedge clk);
    #1;
    checkCount++;
    if (err_timeout !== 1'b1) begin errorCount++; $display("[TB] FAIL to_set: err_timeout=%b at %0d cycles, required 1", err_timeout, TIMEOUT); end
    checkCount++;
    if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL to_idle: busy=%b, required 0", busy); end
    applyStimulus(8'h80, 1'b1);
    for (int c = 0; c < 1000 && expY.size() != 0; c++) @(posedge clk);
    #1;
    checkCount++;
    if (expY.size() != 0) begin errorCount++; $display("[TB] FAIL to_next_sample: %0d results pending, required 0", expY.size()); end
    checkCount++;
    if (err_timeout !== 1'b1) begin errorCount++; $display("[TB] FAIL to_sticky: err_timeout=%b, required 1", err_timeout); end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(8'h90 + 8'(i), 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if (busy !== 1'b1) begin errorCount++; $display("[TB] FAIL mid_busy_before: got %b, required 1", busy); end
    rst = 1'b1;
    expX.delete();
    expY.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkCount++;
    if (fir_en !== 1'b0) begin errorCount++; $display("[TB] FAIL mid_fir_en: got %b, required 0", fir_en); end
    checkCount++;
    if (m_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL mid_m_valid: got %b, required 0", m_valid); end
    checkCount++;
    if (s_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL mid_s_ready: got %b, required 1", s_ready); end
    checkCount++;
    if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL mid_busy: got %b, required 0", busy); end
    checkCount++;
    if (err_timeout !== 1'b0) begin errorCount++; $display("[TB] FAIL mid_err_clear: got %b, required 0", err_timeout); end
    yDrive     = 8'hAA;
    strayValid = 1'b1;
    @(posedge clk);
    #1;
    strayValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if (m_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL stray_m_valid: got %b, required 0", m_valid); end
    checkCount++;
    if (m_data !== 8'h00) begin errorCount++; $display("[TB] FAIL stray_m_data: got 0x%02h, required 0x00", m_data); end
    checkCount++;
    if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL stray_busy: got %b, required 0", busy); end
  endtask

  task automatic test_rescnt();
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(8'hA0 + 8'(i), 1'b1);
    for (int c = 0; c < 1500 && expY.size() != 0; c++) @(posedge clk);
    @(posedge clk);
    #1;
    checkCount++;
    if (expY.size() != 0) begin errorCount++; $display("[TB] FAIL rc_drain: %0d results pending, required 0", expY.size()); end
    checkCount++;
    if (res_count !== RES_EXP) begin errorCount++; $display("[TB] FAIL res_count: got %0d, required %0d", res_count, RES_EXP); end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_rescnt();
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
